// File: rtl/interrupt_controller_multi.sv
// rtl/interrupt_controller_multi.sv - multi-line fixed-priority interrupt controller with vector and EOI handshake
module interrupt_controller_multi #(
    parameter int          NUM_IRQ       = 8,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter int          VECTOR_STRIDE = 4,
    parameter int          ID_W          = 5
) (
    input  logic               clk_from_external,
    input  logic               reset_from_external,
    input  logic [NUM_IRQ-1:0] irq_from_external,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               interrupt_request_to_cpu,
    output logic [31:0]        interrupt_vector_to_cpu,
    output logic [ID_W-1:0]    interrupt_id_to_cpu,
    input  logic               interrupt_grant_from_pc,
    input  logic               interrupt_return_from_cpu
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_e;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] edge_mode_q, edge_mode_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        vector_q, vector_d;

    logic [NUM_IRQ-1:0] s, rise, eligible, w1c, grant_clr, clr, id_onehot;
    logic               any_eligible;
    logic [ID_W-1:0]    win_id;
    logic [31:0]        win_vector;
    logic [31:0]        status;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise      = s & ~prev_q;
    assign eligible  = pending_q & enable_q;
    assign id_onehot = NUM_IRQ'(1) << id_q;

    always_comb begin
        sync_d[0] = irq_from_external;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = s;
    end

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_id       = '0;
        any_eligible = 1'b0;
        for (int i = NUM_IRQ-1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id       = ID_W'(i);
                any_eligible = 1'b1;
            end
        end
        win_vector = VECTOR_BASE + 32'(win_id) * 32'(VECTOR_STRIDE);
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        vector_d  = vector_q;
        grant_clr = '0;
        case (state_q)
            IDLE: begin
                if (any_eligible) begin
                    state_d  = REQUEST;
                    id_d     = win_id;
                    vector_d = win_vector;
                end
            end
            REQUEST: begin
                if (interrupt_grant_from_pc) begin
                    state_d   = SERVICE;
                    grant_clr = id_onehot;
                end else if ((eligible & id_onehot) == '0) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (interrupt_return_from_cpu) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge bits are sticky with set-over-clear; level bits just follow s one cycle late.
    always_comb begin
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        w1c         = '0;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    enable_d    = cfg_wdata[NUM_IRQ-1:0];
                2'd1:    edge_mode_d = cfg_wdata[NUM_IRQ-1:0];
                2'd2:    w1c         = cfg_wdata[NUM_IRQ-1:0];
                default: ;
            endcase
        end
        clr       = w1c | grant_clr;
        pending_d = (((pending_q & ~clr) | rise) & edge_mode_q) | (s & ~edge_mode_q);
    end

    always_comb begin
        status       = '0;
        status[0]    = (state_q == SERVICE);
        status[1]    = (state_q == REQUEST);
        status[12:8] = 5'(id_q);
        case (cfg_addr)
            2'd0:    cfg_rdata = 32'(enable_q);
            2'd1:    cfg_rdata = 32'(edge_mode_q);
            2'd2:    cfg_rdata = 32'(pending_q & edge_mode_q);
            default: cfg_rdata = status;
        endcase
    end

    always_ff @(posedge clk_from_external or negedge reset_from_external) begin
        if (!reset_from_external) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q      <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            pending_q   <= '0;
            state_q     <= IDLE;
            id_q        <= '0;
            vector_q    <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q      <= prev_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            id_q        <= id_d;
            vector_q    <= vector_d;
        end
    end

    assign interrupt_request_to_cpu = (state_q == REQUEST);
    assign interrupt_vector_to_cpu  = vector_q;
    assign interrupt_id_to_cpu      = id_q;

endmodule
